ysyx_25030081_ifu: RTL and testbench
====================================

# ysyx_25030081_ifu

Instruction fetch unit for the multi-cycle NPC core. It holds the PC, fetches one 32-bit instruction per round over a valid/ready instruction-memory interface, and presents it, tagged with its PC, to the decode stage (the control unit and immediate extender). It then waits for the execute/write-back stage to commit a next PC before starting the next fetch. Fetch faults (misaligned next PC, memory error) are flagged and halt fetching.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC of the first fetch after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address (current PC).
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_resp_valid`  in  1  fetch response valid.
- `imem_resp_data`  in  32  fetched instruction word.
- `imem_resp_err`  in  1  access fault; qualified by `imem_resp_valid`.
- `inst_valid`  out  1  `inst` / `inst_pc` are valid for decode.
- `inst`  out  32  instruction word to decode.
- `inst_pc`  out  32  PC of `inst`.
- `inst_ready`  in  1  decode accepts the instruction.
- `commit_valid`  in  1  the current instruction has retired; `next_pc` is valid.
- `next_pc`  in  32  PC of the next instruction (pc+4, branch or jump target).
- `fetch_err`  out  1  sticky fault flag.
- `retire_cnt`  out  32  count of committed instructions; wraps mod 2^32.

## Operation
- FSM states: IDLE (reset state), REQ, WAIT_RESP, DELIVER, WAIT_COMMIT, ERR.
- IDLE: all outputs are idle. Moves to REQ unconditionally on the first edge with `rst_n` high.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=pc.
  - If `imem_req_ready`=1, go to WAIT_RESP.
  - Otherwise hold. The address stays stable while valid is high.
- WAIT_RESP: waits for `imem_resp_valid`.
  - Response with `imem_resp_err`=0: latch `inst`<=`imem_resp_data` and `inst_pc`<=pc, then go to DELIVER.
  - Response with `imem_resp_err`=1: go to ERR and set `fetch_err`.
  - A response arriving while in REQ (including the acceptance cycle) is ignored. Memory must respond one or more cycles after acceptance.
- DELIVER: `inst_valid`=1; `inst` and `inst_pc` stay stable until the handshake.
  - `inst_ready`=1 and `commit_valid`=0: go to WAIT_COMMIT.
  - `inst_ready`=1 and `commit_valid`=1 in the same cycle (single-cycle back end): perform the commit action and skip WAIT_COMMIT.
  - `commit_valid` without `inst_ready`: ignored.
- WAIT_COMMIT: on `commit_valid`, perform the commit action.
- Commit action:
  - `retire_cnt`<=`retire_cnt`+1.
  - If `next_pc[1:0]`==0: pc<=`next_pc` and go to REQ.
  - Otherwise: go to ERR and set `fetch_err`. pc is still loaded with `next_pc`, for debug.
- ERR: no requests and `inst_valid`=0. Only reset exits this state. `fetch_err` stays 1.
- Only one instruction is in flight; there is no prefetch and no speculation.
- Arithmetic: pc and `retire_cnt` are 32-bit and wrap silently.

## Timing
- Reset values (applied asynchronously while `rst_n`=0):
  - state=IDLE, pc=`RESET_PC`.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=32'h0, `inst_pc`=`RESET_PC`.
  - `fetch_err`=0, `retire_cnt`=0.
- `imem_req_valid` and `inst_valid` are Moore outputs decoded from registered state. There is no combinational path from any input to them.
- `imem_req_addr` equals pc directly from the register.
- Minimum round trip (ready=1, response one cycle after acceptance, commit in the same cycle as `inst_ready`):
  - Request accepted in cycle N.
  - Response in cycle N+1.
  - `inst_valid` high in cycle N+2.
  - Next request in cycle N+3. Throughput is one instruction per 3 cycles.
- Reset asserted mid-operation, in any state, returns to IDLE at once. An outstanding memory response after reset is ignored, because it arrives in IDLE or REQ.

## Test plan
- Reset release with `RESET_PC`=32'h8000_0000 and ready=1 -> `imem_req_valid` rises 1 cycle after release with addr 32'h8000_0000. All other outputs hold their reset values until then.
- Memory returns 32'h0010_0093 one cycle after acceptance, and decode asserts `inst_ready` with `commit_valid` and `next_pc`=32'h8000_0004 -> `inst_valid` for exactly 1 cycle with `inst_pc`=32'h8000_0000. Next request at 32'h8000_0004, 3 cycles after the first. `retire_cnt`=1.
- `imem_req_ready` held low 4 cycles, then `inst_ready` low 3 cycles -> valid and addr stable throughout each stall. `inst` unchanged. Exactly one request is accepted.
- Commit arrives 5 cycles after `inst_ready` with `next_pc`=32'h8000_0100 (jump) -> IFU idles in WAIT_COMMIT with no request, then fetches 32'h8000_0100.
- `next_pc`=32'h8000_0102 -> `fetch_err`=1 from the next cycle. No further `imem_req_valid`, and it stays that way until `rst_n` pulses low.
- Response with `imem_resp_err`=1 -> `fetch_err`=1 and `inst_valid` never asserted. Asserting `rst_n`=0 mid-WAIT_RESP clears everything to reset values, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/ysyx_25030081_ifu.sv
// ysyx_25030081_ifu: instruction fetch unit for the multi-cycle NPC core.
// It fetches one word per round at pc, hands it to decode tagged with its PC,
// and then waits for the back end to commit the next PC before fetching again.
// A misaligned next PC or a memory access fault parks the unit in ERR, and
// only reset brings it out.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   imem_req_valid/addr/ready       fetch request channel (addr is pc)
//   imem_resp_valid/data/err        fetch response channel
//   inst_valid/inst/inst_pc/ready   instruction handed to decode
//   commit_valid, next_pc           retirement of current instruction
//   fetch_err                       sticky fault flag
//   retire_cnt                      committed instruction count (wraps)
//
// state        | meaning
// -------------+----------------------------------------------------
// S_IDLE       | just out of reset, starts fetching on the next edge
// S_REQ        | request for pc is valid, waiting for imem_req_ready
// S_WAIT_RESP  | request accepted, waiting for the memory response
// S_DELIVER    | inst/inst_pc valid, waiting for decode handshake
// S_WAIT_COMMIT| decode took the instruction, waiting for commit
// S_ERR        | fetch fault, no further activity until reset
module ysyx_25030081_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [31:0] next_pc,
  output logic        fetch_err,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_DELIVER,
    S_WAIT_COMMIT,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        commit_fire;

  // A commit is only honoured once decode has taken the instruction; a
  // single-cycle back end may commit in the same cycle as the handshake.
  assign commit_fire = commit_valid &&
                       ((state == S_WAIT_COMMIT) ||
                        ((state == S_DELIVER) && inst_ready));

  assign imem_req_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst           <= 32'h0;
      inst_pc        <= RESET_PC;
      fetch_err      <= 1'b0;
      retire_cnt     <= 32'h0;
    end else if (commit_fire) begin
      retire_cnt <= retire_cnt + 32'd1;
      inst_valid <= 1'b0;
      // pc takes next_pc even when misaligned so the faulting target is visible
      pc         <= next_pc;
      if (next_pc[1:0] == 2'b00) begin
        state          <= S_REQ;
        imem_req_valid <= 1'b1;
      end else begin
        state     <= S_ERR;
        fetch_err <= 1'b1;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            state          <= S_WAIT_RESP;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT_RESP: begin
          if (imem_resp_valid) begin
            if (imem_resp_err) begin
              state     <= S_ERR;
              fetch_err <= 1'b1;
            end else begin
              inst       <= imem_resp_data;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              state      <= S_DELIVER;
            end
          end
        end
        S_DELIVER: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= S_WAIT_COMMIT;
          end
        end
        S_WAIT_COMMIT: begin
        end
        S_ERR: begin
        end
        default: begin
          state          <= S_IDLE;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25030081_ifu.sv
module tb_ysyx_25030081_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        inst_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] next_pc = 32'h0;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic [31:0] retire_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ysyx_25030081_ifu #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .imem_resp_err  (imem_resp_err),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .commit_valid   (commit_valid),
    .next_pc        (next_pc),
    .fetch_err      (fetch_err),
    .retire_cnt     (retire_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: which handshake the unit is waiting on.
  bit          m_boot, m_req, m_wait, m_hold, m_cwait, m_fault;
  logic [31:0] m_pc, m_inst, m_ipc, m_ret;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 0; m_req <= 0; m_wait <= 0; m_hold <= 0; m_cwait <= 0; m_fault <= 0;
      m_pc <= RST_PC; m_inst <= 32'h0; m_ipc <= RST_PC; m_ret <= 32'h0;
    end else if (!m_boot) begin
      m_boot <= 1;
      m_req  <= 1;
    end else if (m_req) begin
      if (imem_req_ready) begin
        m_req  <= 0;
        m_wait <= 1;
      end
    end else if (m_wait) begin
      if (imem_resp_valid) begin
        m_wait <= 0;
        if (imem_resp_err) m_fault <= 1;
        else begin
          m_hold <= 1;
          m_inst <= imem_resp_data;
          m_ipc  <= m_pc;
        end
      end
    end else if ((m_hold && inst_ready) || m_cwait) begin
      if (commit_valid) begin
        m_hold  <= 0;
        m_cwait <= 0;
        m_ret   <= m_ret + 1;
        m_pc    <= next_pc;
        if (next_pc % 4 == 0) m_req <= 1;
        else m_fault <= 1;
      end else begin
        m_hold  <= 0;
        m_cwait <= 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
    chk("cyc_req_addr", imem_req_addr, m_pc);
    chk("cyc_inst_valid", {31'b0, inst_valid}, {31'b0, m_hold});
    chk("cyc_inst", inst, m_inst);
    chk("cyc_inst_pc", inst_pc, m_ipc);
    chk("cyc_fetch_err", {31'b0, fetch_err}, {31'b0, m_fault});
    chk("cyc_retire_cnt", retire_cnt, m_ret);
  end

  // Inputs change on the falling edge; the following rising edge consumes them.
  task automatic drv(input bit rst, input bit rdy, input bit rv, input logic [31:0] rd,
                     input bit re, input bit ir, input bit cv, input logic [31:0] np);
    @(negedge clk);
    rst_n           = rst;
    imem_req_ready  = rdy;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    imem_resp_err   = re;
    inst_ready      = ir;
    commit_valid    = cv;
    next_pc         = np;
  endtask

  initial begin
    // reset held
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);
    chk("rst_retire", retire_cnt, 0);
    // release, still IDLE this cycle
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("idle_req_valid", {31'b0, imem_req_valid}, 0);
    // cycle N: first request accepted
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("first_req_valid", {31'b0, imem_req_valid}, 1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    // N+1: response
    drv(1, 1, 1, 32'h0010_0093, 0, 0, 0, 0);
    chk("n1_req_valid", {31'b0, imem_req_valid}, 0);
    // N+2: deliver + single-cycle commit
    drv(1, 0, 0, 0, 0, 1, 1, 32'h8000_0004);
    chk("n2_inst_valid", {31'b0, inst_valid}, 1);
    chk("n2_inst", inst, 32'h0010_0093);
    chk("n2_inst_pc", inst_pc, 32'h8000_0000);
    // N+3..N+6: next request, ready low, a stray response is ignored
    for (int i = 0; i < 4; i++) begin
      drv(1, 0, (i == 1), 32'hDEAD_BEEF, 0, 0, 0, 0);
      chk("stall_req_valid", {31'b0, imem_req_valid}, 1);
      chk("stall_req_addr", imem_req_addr, 32'h8000_0004);
      chk("stall_inst_valid", {31'b0, inst_valid}, 0);
    end
    chk("retire_after_first", retire_cnt, 1);
    // N+7 accept, N+8 nothing, N+9 response
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("accept2_req_valid", {31'b0, imem_req_valid}, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    chk("accept2_once", {31'b0, imem_req_valid}, 0);
    drv(1, 0, 1, 32'h0040_0113, 0, 0, 0, 0);
    // decode stalls 3 cycles; a premature commit is ignored
    for (int i = 0; i < 3; i++) begin
      drv(1, 0, 0, 0, 0, 0, (i == 1), 32'h8000_0008);
      chk("dstall_inst_valid", {31'b0, inst_valid}, 1);
      chk("dstall_inst", inst, 32'h0040_0113);
      chk("dstall_inst_pc", inst_pc, 32'h8000_0004);
    end
    drv(1, 0, 0, 0, 0, 1, 0, 0);
    chk("hs_inst_valid", {31'b0, inst_valid}, 1);
    // waiting for commit for 4 more cycles
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 0, 0, 0, 0, 0, 0);
      chk("wc_req_valid", {31'b0, imem_req_valid}, 0);
      chk("wc_inst_valid", {31'b0, inst_valid}, 0);
    end
    // commit 5 cycles after handshake: jump
    drv(1, 1, 0, 0, 0, 0, 1, 32'h8000_0100);
    chk("wc_last_req_valid", {31'b0, imem_req_valid}, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("jump_req_valid", {31'b0, imem_req_valid}, 1);
    chk("jump_addr", imem_req_addr, 32'h8000_0100);
    chk("retire_two", retire_cnt, 2);
    drv(1, 1, 1, 32'h0000_0073, 0, 0, 0, 0);
    // deliver, commit misaligned target
    drv(1, 1, 0, 0, 0, 1, 1, 32'h8000_0102);
    chk("mis_inst_pc", inst_pc, 32'h8000_0100);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("mis_fetch_err", {31'b0, fetch_err}, 1);
    chk("mis_retire", retire_cnt, 3);
    chk("mis_pc", imem_req_addr, 32'h8000_0102);
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 1, 32'h1234_5678, 0, 1, 1, 32'h8000_0000);
      chk("err_no_req", {31'b0, imem_req_valid}, 0);
      chk("err_sticky", {31'b0, fetch_err}, 1);
    end
    // reset pulse clears the fault
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst2_fetch_err", {31'b0, fetch_err}, 0);
    chk("rst2_retire", retire_cnt, 0);
    chk("rst2_addr", imem_req_addr, RST_PC);
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst2_req_valid", {31'b0, imem_req_valid}, 1);
    // memory fault response
    drv(1, 1, 1, 32'hFFFF_FFFF, 1, 1, 0, 0);
    chk("ferr_pre", {31'b0, fetch_err}, 0);
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 0, 0, 0, 1, 1, 32'h8000_0004);
      chk("ferr_flag", {31'b0, fetch_err}, 1);
      chk("ferr_no_inst", {31'b0, inst_valid}, 0);
      chk("ferr_no_req", {31'b0, imem_req_valid}, 0);
    end
    // reset again, then reset in the middle of WAIT_RESP
    drv(0, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst3_req_valid", {31'b0, imem_req_valid}, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst3_waiting", {31'b0, imem_req_valid}, 0);
    drv(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    #1;
    chk("midrst_inst_valid", {31'b0, inst_valid}, 0);
    chk("midrst_fetch_err", {31'b0, fetch_err}, 0);
    chk("midrst_addr", imem_req_addr, RST_PC);
    // late response lands in IDLE and REQ and must be ignored
    drv(1, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    drv(1, 0, 1, 32'hBAD0_BAD0, 0, 0, 0, 0);
    chk("restart_req_valid", {31'b0, imem_req_valid}, 1);
    chk("restart_addr", imem_req_addr, RST_PC);
    drv(1, 1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 1, 32'h0000_0013, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 1, 32'h8000_0004);
    chk("restart_inst", inst, 32'h0000_0013);
    chk("restart_inst_pc", inst_pc, RST_PC);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    chk("restart_next_addr", imem_req_addr, 32'h8000_0004);
    chk("restart_retire", retire_cnt, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
